// File: rtl/exec_pkg.sv
// Shared types for the execute-stage issue/writeback scheduler:
// FU classes, run states, slot-pipeline entries and per-class latency lookup.
package exec_pkg;

   // Widest destination address a slot entry can carry (RFSZLOG2 must not exceed it).
   localparam int RD_W_MAX = 8;

   typedef enum logic [1:0] {
      FU_MUL = 2'd0,
      FU_LIN = 2'd1,
      FU_TPL = 2'd2,
      FU_INV = 2'd3
   } fu_class_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } run_state_e;

   typedef struct packed {
      logic                valid;
      logic [RD_W_MAX-1:0] rd;
      fu_class_e           fu;
   } slot_t;

   function automatic int lat_of(input fu_class_e c, input int l0, input int l1,
                                 input int l2, input int l3);
      case (c)
         FU_MUL:  return l0;
         FU_LIN:  return l1;
         FU_TPL:  return l2;
         FU_INV:  return l3;
         default: return l0;
      endcase
   endfunction

endpackage

// File: rtl/exec_scoreboard.sv
// Per-register pending bits; hazard reads see a same-cycle writeback clear,
// and a same-cycle set on the cleared register wins.
module exec_scoreboard
   import exec_pkg::*;
#(
   parameter int RFSZLOG2 = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                set_en,
   input  logic [RFSZLOG2-1:0] set_addr,
   input  logic                clr_en,
   input  logic [RFSZLOG2-1:0] clr_addr,
   input  logic [RFSZLOG2-1:0] rs0_addr,
   input  logic [RFSZLOG2-1:0] rs1_addr,
   input  logic [RFSZLOG2-1:0] rd_addr,
   output logic                rs0_haz,
   output logic                rs1_haz,
   output logic                rd_haz
);

   localparam int NREG = 1 << RFSZLOG2;

   logic [NREG-1:0] pend_q;
   logic [NREG-1:0] pend_d;
   logic [NREG-1:0] pend_eff;
   logic [NREG-1:0] clr_mask;
   logic [NREG-1:0] set_mask;

   // Apply clear before set; register 0 can never become pending.
   always_comb begin
      clr_mask           = '0;
      set_mask           = '0;
      clr_mask[clr_addr] = clr_en;
      set_mask[set_addr] = set_en && (set_addr != '0);
      pend_eff           = pend_q & ~clr_mask;
      pend_d             = pend_eff | set_mask;
      pend_d[0]          = 1'b0;
      rs0_haz            = pend_eff[rs0_addr];
      rs1_haz            = pend_eff[rs1_addr];
      rd_haz             = pend_eff[rd_addr];
   end

   // Pending-bit register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

endmodule

// File: rtl/exec_issue_sched.sv
// Issue/writeback scheduler for four fixed-latency FU classes: hazard and
// writeback-slot stalls, one-hot FU enables, merged RF write port, halt drain.
module exec_issue_sched
   import exec_pkg::*;
#(
   parameter int WORDSZ   = 256,
   parameter int RFSZLOG2 = 5,
   parameter int LAT0     = 21,
   parameter int LAT1     = 2,
   parameter int LAT2     = 3,
   parameter int LAT3     = 8,
   parameter int MAXLAT   = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         run_if,
   input  logic                         halt_ex,
   input  logic                         iss_valid,
   output logic                         iss_ready,
   input  logic [1:0]                   iss_fu,
   input  logic [RFSZLOG2-1:0]          iss_rd,
   input  logic [RFSZLOG2-1:0]          iss_rs0,
   input  logic [RFSZLOG2-1:0]          iss_rs1,
   input  logic                         iss_use_rs1,
   output logic [3:0]                   fu_en,
   input  logic [3:0][WORDSZ-1:0]       fu_res,
   output logic                         wen_ex,
   output logic [RFSZLOG2-1:0]          waddr_ex,
   output logic [WORDSZ-1:0]            res_ex,
   output logic                         run_ex,
   output logic [$clog2(MAXLAT+1)-1:0]  inflight
);

   localparam int CNT_W = $clog2(MAXLAT + 1);

   slot_t [MAXLAT-1:0] slot_q;
   slot_t [MAXLAT-1:0] slot_d;
   slot_t              new_ent;
   logic [CNT_W-1:0]   inflight_q;
   logic [CNT_W-1:0]   inflight_d;
   run_state_e         state_q;
   run_state_e         state_d;
   logic [1:0]         wb_fu;
   logic               rs0_haz;
   logic               rs1_haz;
   logic               rd_haz;
   logic               slot_busy;
   logic               halt_pend;
   logic               fire;
   int                 lat_sel;

   exec_scoreboard #(.RFSZLOG2(RFSZLOG2)) u_sb (
      .clk      (clk),
      .rst      (rst),
      .set_en   (fire),
      .set_addr (iss_rd),
      .clr_en   (wen_ex),
      .clr_addr (waddr_ex),
      .rs0_addr (iss_rs0),
      .rs1_addr (iss_rs1),
      .rd_addr  (iss_rd),
      .rs0_haz  (rs0_haz),
      .rs1_haz  (rs1_haz),
      .rd_haz   (rd_haz)
   );

   // Writeback port driven straight from slot entry 0.
   always_comb begin
      wb_fu    = slot_q[0].fu;
      wen_ex   = slot_q[0].valid && (slot_q[0].rd != '0);
      waddr_ex = slot_q[0].valid ? slot_q[0].rd[RFSZLOG2-1:0] : '0;
      res_ex   = slot_q[0].valid ? fu_res[wb_fu] : '0;
   end

   // Issue decision; a class whose latency equals MAXLAT always finds its slot free.
   always_comb begin
      lat_sel   = lat_of(fu_class_e'(iss_fu), LAT0, LAT1, LAT2, LAT3);
      slot_busy = 1'b0;
      for (int i = 1; i < MAXLAT; i++) begin
         slot_busy = slot_busy | (slot_q[i].valid & (i == lat_sel));
      end
      halt_pend = (state_q == ST_DRAIN) || ((state_q == ST_RUN) && halt_ex);
      iss_ready = !rs0_haz && !(iss_use_rs1 && rs1_haz) && !rd_haz
                  && !slot_busy && !halt_pend;
      fire      = iss_valid && iss_ready;
      fu_en     = fire ? (4'b0001 << iss_fu) : 4'b0000;
   end

   // Slot shift/load and outstanding-op count.
   always_comb begin
      new_ent.valid = 1'b1;
      new_ent.rd    = RD_W_MAX'(iss_rd);
      new_ent.fu    = fu_class_e'(iss_fu);
      slot_d        = slot_q >> $bits(slot_t);
      for (int i = 0; i < MAXLAT; i++) begin
         slot_d[i] = (fire && (i == lat_sel - 1)) ? new_ent : slot_d[i];
      end
      inflight_d = inflight_q + CNT_W'(fire) - CNT_W'(slot_q[0].valid);
      inflight   = inflight_q;
   end

   // Run/halt state machine; drain ends once the count reaches zero after this cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  state_d = (run_if && fire) ? ST_RUN : ST_IDLE;
         ST_RUN:   state_d = halt_ex ? ST_DRAIN : ST_RUN;
         ST_DRAIN: state_d = (inflight_d == '0) ? ST_IDLE : ST_DRAIN;
         default:  state_d = ST_IDLE;
      endcase
      run_ex = (state_q != ST_IDLE) || wen_ex;
   end

   // Scheduler state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q     <= '0;
         inflight_q <= '0;
         state_q    <= ST_IDLE;
      end else begin
         slot_q     <= slot_d;
         inflight_q <= inflight_d;
         state_q    <= state_d;
      end
   end

endmodule

// File: tb/tb_exec_issue_sched.sv
// Directed bench for exec_issue_sched: cycle t starts 1 time unit after a rising
// edge, inputs are driven then, outputs are sampled 3 units later.
module tb_exec_issue_sched;

   logic              clk = 1'b0;
   logic              rst;
   logic              run_if;
   logic              halt_ex;
   logic              iss_valid;
   logic              iss_ready;
   logic [1:0]        iss_fu;
   logic [4:0]        iss_rd;
   logic [4:0]        iss_rs0;
   logic [4:0]        iss_rs1;
   logic              iss_use_rs1;
   logic [3:0]        fu_en;
   logic [3:0][255:0] fu_res;
   logic              wen_ex;
   logic [4:0]        waddr_ex;
   logic [255:0]      res_ex;
   logic              run_ex;
   logic [5:0]        inflight;

   int n_checks = 0;
   int n_errors = 0;
   int t_now    = 0;

   exec_issue_sched dut (
      .clk         (clk),
      .rst         (rst),
      .run_if      (run_if),
      .halt_ex     (halt_ex),
      .iss_valid   (iss_valid),
      .iss_ready   (iss_ready),
      .iss_fu      (iss_fu),
      .iss_rd      (iss_rd),
      .iss_rs0     (iss_rs0),
      .iss_rs1     (iss_rs1),
      .iss_use_rs1 (iss_use_rs1),
      .fu_en       (fu_en),
      .fu_res      (fu_res),
      .wen_ex      (wen_ex),
      .waddr_ex    (waddr_ex),
      .res_ex      (res_ex),
      .run_ex      (run_ex),
      .inflight    (inflight)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] res_of(input int c);
      return {8{32'hC0DE_0000 | 32'(c)}};
   endfunction

   task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at t=%0d: got %0h expected %0h", tag, t_now, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      t_now++;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic goto(input int t);
      while (t_now < t) tick();
   endtask

   task automatic offer(input logic [1:0] fu, input logic [4:0] rd, input logic [4:0] rs0,
                        input logic [4:0] rs1, input logic use1);
      iss_valid   = 1'b1;
      iss_fu      = fu;
      iss_rd      = rd;
      iss_rs0     = rs0;
      iss_rs1     = rs1;
      iss_use_rs1 = use1;
   endtask

   task automatic drop();
      iss_valid   = 1'b0;
      iss_fu      = 2'd0;
      iss_rd      = 5'd0;
      iss_rs0     = 5'd0;
      iss_rs1     = 5'd0;
      iss_use_rs1 = 1'b0;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      run_if  = 1'b1;
      halt_ex = 1'b0;
      drop();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst   = 1'b0;
      t_now = 0;
   endtask

   initial begin
      for (int c = 0; c < 4; c++) fu_res[c] = res_of(c);

      // Reset state
      do_reset();
      settle();
      check_val("rst_ready", iss_ready, 1'b1);
      check_val("rst_fu_en", fu_en, 4'b0000);
      check_val("rst_wen", wen_ex, 1'b0);
      check_val("rst_waddr", waddr_ex, 5'd0);
      check_val("rst_res", res_ex, 256'd0);
      check_val("rst_run", run_ex, 1'b0);
      check_val("rst_inflight", inflight, 6'd0);

      // Single mul: rd=3, writeback at t=21
      do_reset();
      offer(2'd0, 5'd3, 5'd0, 5'd0, 1'b0);
      settle();
      check_val("mul_ready", iss_ready, 1'b1);
      check_val("mul_fu_en", fu_en, 4'b0001);
      tick();
      drop();
      settle();
      check_val("mul_inflight1", inflight, 6'd1);
      check_val("mul_fu_en_off", fu_en, 4'b0000);
      goto(20);
      settle();
      check_val("mul_wen_t20", wen_ex, 1'b0);
      goto(21);
      settle();
      check_val("mul_wen_t21", wen_ex, 1'b1);
      check_val("mul_waddr", waddr_ex, 5'd3);
      check_val("mul_res", res_ex, res_of(0));
      goto(22);
      settle();
      check_val("mul_inflight0", inflight, 6'd0);
      check_val("mul_wen_t22", wen_ex, 1'b0);

      // Slot collision: LIN offered at t=19 stalls, fires at t=20
      do_reset();
      offer(2'd0, 5'd3, 5'd0, 5'd0, 1'b0);
      tick();
      drop();
      goto(19);
      offer(2'd1, 5'd4, 5'd0, 5'd0, 1'b0);
      settle();
      check_val("col_ready_t19", iss_ready, 1'b0);
      check_val("col_fu_en_t19", fu_en, 4'b0000);
      goto(20);
      settle();
      check_val("col_ready_t20", iss_ready, 1'b1);
      check_val("col_fu_en_t20", fu_en, 4'b0010);
      tick();
      drop();
      settle();
      check_val("col_mul_waddr", waddr_ex, 5'd3);
      goto(22);
      settle();
      check_val("col_lin_wen", wen_ex, 1'b1);
      check_val("col_lin_waddr", waddr_ex, 5'd4);
      check_val("col_lin_res", res_ex, res_of(1));

      // RAW stall: LIN rs0=5 waits for MUL rd=5
      do_reset();
      offer(2'd0, 5'd5, 5'd0, 5'd0, 1'b0);
      tick();
      offer(2'd1, 5'd6, 5'd5, 5'd0, 1'b0);
      settle();
      check_val("raw_ready_t1", iss_ready, 1'b0);
      goto(20);
      settle();
      check_val("raw_ready_t20", iss_ready, 1'b0);
      goto(21);
      settle();
      check_val("raw_ready_t21", iss_ready, 1'b1);
      check_val("raw_mul_wen", wen_ex, 1'b1);
      tick();
      drop();
      goto(23);
      settle();
      check_val("raw_lin_wen", wen_ex, 1'b1);
      check_val("raw_lin_waddr", waddr_ex, 5'd6);

      // rs1 ignored unless use_rs1, then RAW through rs1
      do_reset();
      offer(2'd1, 5'd9, 5'd0, 5'd0, 1'b0);
      tick();
      offer(2'd2, 5'd10, 5'd0, 5'd9, 1'b0);
      settle();
      check_val("rs1_unused_ready", iss_ready, 1'b1);
      iss_rd      = 5'd11;
      iss_use_rs1 = 1'b1;
      settle();
      check_val("rs1_used_ready", iss_ready, 1'b0);
      tick();
      drop();

      // Throughput: four LIN rd=1..4 back to back
      do_reset();
      for (int t = 0; t < 7; t++) begin
         if (t < 4) offer(2'd1, 5'(t + 1), 5'd0, 5'd0, 1'b0);
         else drop();
         settle();
         if (t < 4) check_val("thr_fu_en", fu_en, 4'b0010);
         if (t >= 2 && t <= 5) begin
            check_val("thr_wen", wen_ex, 1'b1);
            check_val("thr_waddr", waddr_ex, 5'(t - 1));
         end
         if (t == 4) check_val("thr_inflight_t4", inflight, 6'd2);
         if (t == 6) check_val("thr_inflight_t6", inflight, 6'd0);
         tick();
      end

      // WAW: second LIN rd=1 waits for the first writeback, then RAW on it
      do_reset();
      offer(2'd1, 5'd1, 5'd0, 5'd0, 1'b0);
      tick();
      settle();
      check_val("waw_ready_t1", iss_ready, 1'b0);
      goto(2);
      settle();
      check_val("waw_ready_t2", iss_ready, 1'b1);
      check_val("waw_wen_t2", wen_ex, 1'b1);
      tick();
      offer(2'd1, 5'd7, 5'd1, 5'd0, 1'b0);
      settle();
      check_val("waw_raw_t3", iss_ready, 1'b0);
      goto(4);
      settle();
      check_val("waw_wen_t4", wen_ex, 1'b1);
      check_val("waw_ready_t4", iss_ready, 1'b1);
      tick();
      drop();

      // Halt drain
      do_reset();
      offer(2'd0, 5'd3, 5'd0, 5'd0, 1'b0);
      tick();
      drop();
      settle();
      check_val("halt_run_t1", run_ex, 1'b1);
      goto(2);
      halt_ex = 1'b1;
      offer(2'd1, 5'd8, 5'd0, 5'd0, 1'b0);
      settle();
      check_val("halt_ready_t2", iss_ready, 1'b0);
      tick();
      halt_ex = 1'b0;
      settle();
      check_val("halt_ready_t3", iss_ready, 1'b0);
      drop();
      goto(21);
      settle();
      check_val("halt_run_t21", run_ex, 1'b1);
      check_val("halt_wen_t21", wen_ex, 1'b1);
      tick();
      run_if = 1'b0;
      offer(2'd1, 5'd8, 5'd0, 5'd0, 1'b0);
      settle();
      check_val("halt_run_t22", run_ex, 1'b0);
      check_val("halt_ready_t22", iss_ready, 1'b1);
      tick();
      drop();

      // Halt in IDLE ignored; rd=0 op occupies a slot but never writes
      do_reset();
      run_if  = 1'b0;
      halt_ex = 1'b1;
      offer(2'd1, 5'd0, 5'd0, 5'd0, 1'b0);
      settle();
      check_val("idle_halt_ready", iss_ready, 1'b1);
      check_val("rd0_fu_en", fu_en, 4'b0010);
      tick();
      halt_ex = 1'b0;
      drop();
      settle();
      check_val("rd0_inflight_t1", inflight, 6'd1);
      check_val("idle_run_t1", run_ex, 1'b0);
      tick();
      settle();
      check_val("rd0_wen_t2", wen_ex, 1'b0);
      check_val("rd0_waddr_t2", waddr_ex, 5'd0);
      tick();
      settle();
      check_val("rd0_inflight_t3", inflight, 6'd0);

      // Reset mid-op discards the in-flight MUL
      do_reset();
      offer(2'd0, 5'd3, 5'd0, 5'd0, 1'b0);
      tick();
      drop();
      goto(10);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      check_val("rmid_inflight", inflight, 6'd0);
      check_val("rmid_run", run_ex, 1'b0);
      goto(21);
      settle();
      check_val("rmid_wen_t21", wen_ex, 1'b0);
      check_val("rmid_res_t21", res_ex, 256'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
